// File: rtl/des_decipher_pkg.sv
// Shared DES decipher definitions: widths, FSM states, decryption key schedule,
// permutation tables (pure bit-select wiring) and S-box contents.
package des_decipher_pkg;

  localparam int unsigned BlockW   = 64;
  localparam int unsigned KeyW     = 56;
  localparam int unsigned SubkeyW  = 48;
  localparam int unsigned HalfW    = 32;
  localparam int unsigned KeyHalfW = 28;

  typedef enum logic [1:0] {StIdle, StRound, StDone} des_state_e;

  // Right-rotation applied to C/D before PC2 in decipher rounds 1..16.
  localparam int unsigned RotSched [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Tables hold 1-based DES bit numbers; bit 0 of every vector is DES bit 1.
  localparam int unsigned IpTbl [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FpTbl [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned ETbl [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int unsigned PTbl [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int unsigned SBoxTbl [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(IpTbl[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(FpTbl[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:55] pc1_perm(input logic [0:63] x);
    logic [0:55] y;
    for (int i = 0; i < 56; i++) y[i] = x[6'(Pc1Tbl[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] pc2_perm(input logic [0:55] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[6'(Pc2Tbl[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] e_perm(input logic [0:31] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[5'(ETbl[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] x);
    logic [0:31] y;
    for (int i = 0; i < 32; i++) y[i] = x[5'(PTbl[i] - 1)];
    return y;
  endfunction

  // Row is bits 0 and 5, column bits 1..4.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [0:5] x);
    return 4'(SBoxTbl[n][{x[0], x[5], x[1:4]}]);
  endfunction

  // DES right rotation of a 28-bit key half: bits move toward higher DES numbers.
  function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
    logic [0:27] y;
    case (n)
      2'd1:    y = {x[27], x[0:26]};
      2'd2:    y = {x[26:27], x[0:25]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_decipher_round.sv
// Combinational DES f-function: E expansion, round-key xor, S-boxes, P permutation.
module des_decipher_round
  import des_decipher_pkg::*;
(
  input  logic [0:HalfW-1]   r,
  input  logic [0:SubkeyW-1] round_key,
  output logic [0:HalfW-1]   f
);

  logic [0:SubkeyW-1] x;
  logic [0:HalfW-1]   s_out;

  assign x = e_perm(r) ^ round_key;

  des_sbox1 u_sbox1 (.din(x[0:5]),   .dout(s_out[0:3]));
  des_sbox2 u_sbox2 (.din(x[6:11]),  .dout(s_out[4:7]));
  des_sbox3 u_sbox3 (.din(x[12:17]), .dout(s_out[8:11]));
  des_sbox4 u_sbox4 (.din(x[18:23]), .dout(s_out[12:15]));
  des_sbox5 u_sbox5 (.din(x[24:29]), .dout(s_out[16:19]));
  des_sbox6 u_sbox6 (.din(x[30:35]), .dout(s_out[20:23]));
  des_sbox7 u_sbox7 (.din(x[36:41]), .dout(s_out[24:27]));
  des_sbox8 u_sbox8 (.din(x[42:47]), .dout(s_out[28:31]));

  assign f = p_perm(s_out);

endmodule

// File: rtl/des_sbox1.sv
// DES S-box 1: 6-bit group in, 4-bit substitution out.
module des_sbox1
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd0, din);
endmodule

// File: rtl/des_sbox2.sv
// DES S-box 2: 6-bit group in, 4-bit substitution out.
module des_sbox2
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd1, din);
endmodule

// File: rtl/des_sbox3.sv
// DES S-box 3: 6-bit group in, 4-bit substitution out.
module des_sbox3
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd2, din);
endmodule

// File: rtl/des_sbox4.sv
// DES S-box 4: 6-bit group in, 4-bit substitution out.
module des_sbox4
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd3, din);
endmodule

// File: rtl/des_sbox5.sv
// DES S-box 5: 6-bit group in, 4-bit substitution out.
module des_sbox5
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd4, din);
endmodule

// File: rtl/des_sbox6.sv
// DES S-box 6: 6-bit group in, 4-bit substitution out.
module des_sbox6
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd5, din);
endmodule

// File: rtl/des_sbox7.sv
// DES S-box 7: 6-bit group in, 4-bit substitution out.
module des_sbox7
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd6, din);
endmodule

// File: rtl/des_sbox8.sv
// DES S-box 8: 6-bit group in, 4-bit substitution out.
module des_sbox8
  import des_decipher_pkg::*;
(
  input  logic [0:5] din,
  output logic [0:3] dout
);
  assign dout = sbox_lookup(3'd7, din);
endmodule

// File: rtl/des_decipher_engine.sv
// Iterative DES decipher: one Feistel round per clock, 17-cycle start-to-done latency.
module des_decipher_engine
  import des_decipher_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_strobe_din,
  input  logic [0:BlockW-1] ciphertext_din,
  input  logic [0:BlockW-1] key_din,
  output logic [0:BlockW-1] plaintext_dout,
  output logic              done_strobe_dout,
  output logic              busy_dout
);

  des_state_e          state_q;
  logic [0:HalfW-1]    l_q, r_q;
  logic [0:KeyHalfW-1] c_q, d_q;
  logic [4:0]          cnt_q;
  logic [0:BlockW-1]   plaintext_q;
  logic                done_q, busy_q;

  logic [0:BlockW-1]   ip_out;
  logic [0:KeyW-1]     pc1_out;
  logic [3:0]          sched_idx;
  logic [1:0]          rot_amt;
  logic [0:KeyHalfW-1] c_rot, d_rot;
  logic [0:SubkeyW-1]  round_key;
  logic [0:HalfW-1]    f_out, r_new;
  logic                last_round;

  assign ip_out     = ip_perm(ciphertext_din);
  assign pc1_out    = pc1_perm(key_din);
  assign sched_idx  = 4'(cnt_q - 5'd1);
  assign rot_amt    = 2'(RotSched[sched_idx]);
  assign c_rot      = rotr28(c_q, rot_amt);
  assign d_rot      = rotr28(d_q, rot_amt);
  assign round_key  = pc2_perm({c_rot, d_rot});
  assign r_new      = l_q ^ f_out;
  assign last_round = (cnt_q == 5'd16);

  des_decipher_round u_round (
    .r         (r_q),
    .round_key (round_key),
    .f         (f_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      plaintext_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_strobe_din) begin
            l_q     <= ip_out[0:31];
            r_q     <= ip_out[32:63];
            c_q     <= pc1_out[0:27];
            d_q     <= pc1_out[28:55];
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
            state_q <= StRound;
          end
        end
        StRound: begin
          l_q <= r_q;
          r_q <= r_new;
          if (last_round) begin
            // One extra position closes the 28-step cycle so C/D rest at PC1(key).
            c_q         <= rotr28(c_rot, 2'd1);
            d_q         <= rotr28(d_rot, 2'd1);
            plaintext_q <= fp_perm({r_new, r_q});
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            c_q   <= c_rot;
            d_q   <= d_rot;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign plaintext_dout   = plaintext_q;
  assign done_strobe_dout = done_q;
  assign busy_dout        = busy_q;

endmodule

// File: tb/tb_des_decipher_engine.sv
// Directed and model-based checks of des_decipher_engine using a bench-side DES encipher.
module tb_des_decipher_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [0:63] ct, key, pt;
  logic        done, busy;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  des_decipher_engine dut (
    .clk              (clk),
    .reset            (reset),
    .start_strobe_din (start),
    .ciphertext_din   (ct),
    .key_din          (key),
    .plaintext_dout   (pt),
    .done_strobe_dout (done),
    .busy_dout        (busy)
  );

  // Reference tables indexed with 1-based DES bit numbers on [1:N] vectors.
  localparam int unsigned IpT [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FpT [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int unsigned Pc1T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int unsigned Pc2T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned ET [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int unsigned PT [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int unsigned SbT [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11,
      9, 5, 3, 8, 4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7,
      5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10,
      6, 9, 11, 5, 0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2,
      11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14,
      12, 11, 15, 1, 13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7,
      4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12,
      1, 10, 14, 9, 10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8,
      9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10,
      3, 9, 8, 6, 4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13,
      6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14,
      0, 11, 3, 8, 9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10,
      11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12,
      2, 15, 8, 6, 1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7,
      9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11,
      0, 14, 9, 2, 7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13,
      15, 12, 9, 0, 3, 5, 6, 11}};

  // Forward DES (encipher) with the standard left-shift key schedule.
  function automatic logic [1:64] des_enc(input logic [1:64] k64, input logic [1:64] p64);
    logic [1:64] ipo, pre, res;
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] rk, ex;
    logic [1:32] l, r, sout, f, t;
    logic [5:0]  six;
    int          sh;
    for (int i = 0; i < 64; i++) ipo[i+1] = p64[IpT[i]];
    for (int i = 0; i < 56; i++) cd[i+1] = k64[Pc1T[i]];
    l = ipo[1:32];
    r = ipo[33:64];
    c = cd[1:28];
    d = cd[29:56];
    for (int rnd = 0; rnd < 16; rnd++) begin
      sh = (rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) rk[i+1] = cd[Pc2T[i]];
      for (int i = 0; i < 48; i++) ex[i+1] = r[ET[i]];
      ex = ex ^ rk;
      for (int s = 0; s < 8; s++) begin
        six = ex[s*6+1 +: 6];
        sout[s*4+1 +: 4] = 4'(SbT[s][{six[5], six[0], six[4:1]}]);
      end
      for (int i = 0; i < 32; i++) f[i+1] = sout[PT[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[i+1] = pre[FpT[i]];
    return res;
  endfunction

  typedef struct {
    logic [0:63] key;
    logic [0:63] ct;
    logic [0:63] pt;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [0:63] k, input logic [0:63] c, output logic [0:63] res,
                        output int lat, output int width);
    key   = k;
    ct    = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    res   = pt;
    width = 0;
    while (done && width < 5) begin
      tick();
      width++;
    end
  endtask

  logic [0:63] res, pt_before, rk, rp, rc;
  int          lat, width, dcount;
  logic        hold_ok;

  initial begin
    vecs[0] = '{key: 64'h133457799BBCDFF1, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF};
    vecs[1] = '{key: 64'h0E329232EA6D0D73, ct: 64'h0000000000000000, pt: 64'h8787878787878787};
    vecs[2] = '{key: 64'h0000000000000000, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};
    vecs[3] = '{key: 64'h0101010101010101, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};

    reset = 1'b1;
    start = 1'b0;
    key   = '0;
    ct    = '0;
    tick();
    tick();
    chk("reset_plaintext", pt, 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    reset = 1'b0;

    // First start lands on the first edge after reset release.
    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].key, vecs[v].ct, res, lat, width);
      chk($sformatf("vec%0d_plaintext", v), res, vecs[v].pt);
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd16);
      chk($sformatf("vec%0d_done_width", v), 64'(width), 64'd1);
    end

    chk("model_kat", des_enc(64'h133457799BBCDFF1, 64'h0123456789ABCDEF), 64'h85E813540F0AB405);

    // Starts at cycles 5 and 16 with fresh ciphertext must be ignored.
    pt_before = pt;
    key   = vecs[0].key;
    ct    = vecs[0].ct;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_round", 64'(busy), 64'h1);
    hold_ok = 1'b1;
    dcount  = 0;
    for (int e = 1; e <= 17; e++) begin
      start = (e == 5 || e == 16);
      if (start) ct = {$urandom, $urandom};
      tick();
      start = 1'b0;
      if (done) dcount++;
      if (e <= 15 && pt !== pt_before) hold_ok = 1'b0;
      if (e == 16) begin
        chk("ignored_start_result", pt, vecs[0].pt);
        chk("busy_in_done", 64'(busy), 64'h1);
      end
    end
    chk("single_done", 64'(dcount), 64'd1);
    chk("plaintext_hold_in_round", 64'(hold_ok), 64'h1);
    chk("busy_back_idle", 64'(busy), 64'h0);
    run_op(vecs[1].key, vecs[1].ct, res, lat, width);
    chk("cycle18_start_result", res, vecs[1].pt);
    chk("cycle18_start_latency", 64'(lat), 64'd16);

    // Reset during round 9 aborts the operation.
    key   = vecs[0].key;
    ct    = vecs[0].ct;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset_plaintext", pt, 64'h0);
    chk("midreset_done", 64'(done), 64'h0);
    chk("midreset_busy", 64'(busy), 64'h0);
    tick();
    tick();
    reset  = 1'b0;
    dcount = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (done) dcount++;
    end
    chk("no_done_after_abort", 64'(dcount), 64'd0);
    run_op(vecs[0].key, vecs[0].ct, res, lat, width);
    chk("post_reset_result", res, vecs[0].pt);
    chk("post_reset_latency", 64'(lat), 64'd16);

    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      rc = des_enc(rk, rp);
      run_op(rk, rc, res, lat, width);
      chk($sformatf("rand%0d_plaintext", n), res, rp);
      chk($sformatf("rand%0d_done_width", n), 64'(width), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
